// File: rtl/intra16x16_mb_sequencer.sv
// Frame-level sequencer for the luma 16x16 intra path: walks macroblocks in raster
// order, running fetch -> SAD prediction -> save for each, with neighbour flags.
`timescale 1ns/1ps

module intra16x16_mb_sequencer #(
  parameter int LENGTH    = 1280,
  parameter int WIDTH     = 720,
  parameter int MB_SIZE_L = 16,
  parameter int MB_SIZE_W = 16,
  parameter int SAVE_LAT  = 1,
  parameter int MBNUM_W   = 13,
  localparam int MBS_X    = LENGTH / MB_SIZE_L,
  localparam int MBS_Y    = WIDTH / MB_SIZE_W,
  localparam int NUM_MB   = MBS_X * MBS_Y,
  localparam int X_W      = (MBS_X > 1) ? $clog2(MBS_X) : 1,
  localparam int Y_W      = (MBS_Y > 1) ? $clog2(MBS_Y) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  output logic               busy,
  output logic               frame_done,
  output logic               load_req,
  input  logic               load_ack,
  output logic               pred_start,
  input  logic               pred_done,
  output logic               save_en,
  output logic [MBNUM_W-1:0] mbnumber,
  output logic [X_W-1:0]     mb_x,
  output logic [Y_W-1:0]     mb_y,
  output logic               top_avail,
  output logic               left_avail,
  output logic               protocol_err
);

  localparam int HOLD_W = (SAVE_LAT > 1) ? $clog2(SAVE_LAT) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'((SAVE_LAT > 0) ? SAVE_LAT - 1 : 0);
  localparam logic [X_W-1:0]     LAST_X    = X_W'(MBS_X - 1);
  localparam logic [MBNUM_W-1:0] LAST_MB   = MBNUM_W'(NUM_MB - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_PRED      = 3'd2;
  localparam logic [2:0] S_WAIT_PRED = 3'd3;
  localparam logic [2:0] S_SAVE      = 3'd4;
  localparam logic [2:0] S_HOLD      = 3'd5;
  localparam logic [2:0] S_NEXT      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  logic [2:0]         state_q, state_d;
  logic [MBNUM_W-1:0] mbnumber_q, mbnumber_d;
  logic [X_W-1:0]     mb_x_q, mb_x_d;
  logic [Y_W-1:0]     mb_y_q, mb_y_d;
  logic               top_q, top_d;
  logic               left_q, left_d;
  logic               perr_q, perr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  always_comb begin
    state_d    = state_q;
    mbnumber_d = mbnumber_q;
    mb_x_d     = mb_x_q;
    mb_y_d     = mb_y_q;
    top_d      = top_q;
    left_d     = left_q;
    hold_d     = hold_q;
    perr_d     = perr_q;

    // Handshake inputs outside their own window are dropped but remembered.
    if ((load_ack && state_q != S_LOAD) || (pred_done && state_q != S_WAIT_PRED)) begin
      perr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d    = S_LOAD;
          mbnumber_d = '0;
          mb_x_d     = '0;
          mb_y_d     = '0;
          top_d      = 1'b0;
          left_d     = 1'b0;
          perr_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_ack) state_d = S_PRED;
      end
      S_PRED: state_d = S_WAIT_PRED;
      S_WAIT_PRED: begin
        if (pred_done) state_d = S_SAVE;
      end
      S_SAVE: begin
        hold_d  = '0;
        state_d = (SAVE_LAT > 0) ? S_HOLD : S_NEXT;
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_NEXT;
        else                     hold_d  = hold_q + 1'b1;
      end
      S_NEXT: begin
        if (mbnumber_q == LAST_MB) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_LOAD;
          mbnumber_d = mbnumber_q + 1'b1;
          if (mb_x_q == LAST_X) begin
            mb_x_d = '0;
            mb_y_d = mb_y_q + 1'b1;
            top_d  = 1'b1;
            left_d = 1'b0;
          end else begin
            mb_x_d = mb_x_q + 1'b1;
            left_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mbnumber_q <= '0;
      mb_x_q     <= '0;
      mb_y_q     <= '0;
      top_q      <= 1'b0;
      left_q     <= 1'b0;
      perr_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      mbnumber_q <= mbnumber_d;
      mb_x_q     <= mb_x_d;
      mb_y_q     <= mb_y_d;
      top_q      <= top_d;
      left_q     <= left_d;
      perr_q     <= perr_d;
      hold_q     <= hold_d;
    end
  end

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign frame_done   = (state_q == S_DONE);
  assign load_req     = (state_q == S_LOAD);
  assign pred_start   = (state_q == S_PRED);
  assign save_en      = (state_q == S_SAVE);
  assign mbnumber     = mbnumber_q;
  assign mb_x         = mb_x_q;
  assign mb_y         = mb_y_q;
  assign top_avail    = top_q;
  assign left_avail   = left_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_intra16x16_mb_sequencer.sv
// Directed bench: a 4x2-MB instance for sequencing/handshake/reset cases and a
// full 1280x720 instance for the end-of-frame boundary.
`timescale 1ns/1ps

module tb_intra16x16_mb_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  // small instance: 4x2 MBs, SAVE_LAT=1
  logic        s_fs = 0, s_ack = 0, s_done = 0;
  logic        s_busy, s_fd, s_lr, s_ps, s_save, s_top, s_left, s_perr;
  logic [12:0] s_mbn;
  logic [1:0]  s_x;
  logic [0:0]  s_y;

  // full-size instance: 80x45 MBs, SAVE_LAT=0
  logic        b_fs = 0, b_ack = 0, b_done = 0;
  logic        b_busy, b_fd, b_lr, b_ps, b_save, b_top, b_left, b_perr;
  logic [12:0] b_mbn;
  logic [6:0]  b_x;
  logic [5:0]  b_y;

  intra16x16_mb_sequencer #(
    .LENGTH(64), .WIDTH(32), .MB_SIZE_L(16), .MB_SIZE_W(16), .SAVE_LAT(1), .MBNUM_W(13)
  ) u_small (
    .clk(clk), .reset(rst_n), .frame_start(s_fs), .busy(s_busy), .frame_done(s_fd),
    .load_req(s_lr), .load_ack(s_ack), .pred_start(s_ps), .pred_done(s_done),
    .save_en(s_save), .mbnumber(s_mbn), .mb_x(s_x), .mb_y(s_y),
    .top_avail(s_top), .left_avail(s_left), .protocol_err(s_perr)
  );

  intra16x16_mb_sequencer #(
    .LENGTH(1280), .WIDTH(720), .MB_SIZE_L(16), .MB_SIZE_W(16), .SAVE_LAT(0), .MBNUM_W(13)
  ) u_big (
    .clk(clk), .reset(rst_n), .frame_start(b_fs), .busy(b_busy), .frame_done(b_fd),
    .load_req(b_lr), .load_ack(b_ack), .pred_start(b_ps), .pred_done(b_done),
    .save_en(b_save), .mbnumber(b_mbn), .mb_x(b_x), .mb_y(b_y),
    .top_avail(b_top), .left_avail(b_left), .protocol_err(b_perr)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // responder / tracker state for the small instance
  int cyc, last_save, exp_mb, saves, preds_since, lr_run, pc, fd_cnt, fd_cyc;
  int ack_delay, done_delay, stray_mb, hang_mb, gap_exp, first_exp, mid_fs_cyc;
  bit tied, armed;

  task automatic s_step();
    @(negedge clk);
    cyc++;
    if (s_ps) begin
      preds_since++;
      pc    = 0;
      armed = 1;
    end else if (armed) begin
      pc++;
    end
    if (s_lr) begin
      lr_run++;
    end else begin
      if (lr_run != 0 && !tied) chk("load_req_len", lr_run, ack_delay + 1);
      lr_run = 0;
    end
    if (s_save) begin
      chk("save_mbn", s_mbn, exp_mb);
      chk("save_x", s_x, exp_mb % 4);
      chk("save_y", s_y, exp_mb / 4);
      chk("save_top", s_top, (exp_mb / 4) != 0);
      chk("save_left", s_left, (exp_mb % 4) != 0);
      chk("pred_per_mb", preds_since, 1);
      if (!tied) chk("done_to_save", pc, done_delay + 1);
      if (saves == 0) chk("first_save_cyc", cyc, first_exp);
      else            chk("save_gap", cyc - last_save, gap_exp);
      last_save   = cyc;
      saves++;
      exp_mb++;
      preds_since = 0;
      armed       = 0;
    end
    if (s_fd) begin
      fd_cnt++;
      fd_cyc = cyc;
      chk("busy_in_done", s_busy, 0);
    end
    s_ack  = tied || (s_lr && lr_run == ack_delay + 1);
    s_done = tied || (s_ps && s_mbn == stray_mb) ||
             (armed && !s_ps && pc == done_delay && s_mbn != hang_mb);
  endtask

  task automatic start_frame();
    cyc = 0; saves = 0; exp_mb = 0; fd_cnt = 0; fd_cyc = 0;
    preds_since = 0; armed = 0; lr_run = 0; pc = 0; last_save = 0;
    s_fs = 1;
    s_step();
    s_fs = 0;
    chk("start_busy", s_busy, 1);
    chk("start_mbn", s_mbn, 0);
    chk("start_perr", s_perr, 0);
  endtask

  task automatic run_frame(input int fd_exp, input int bound);
    start_frame();
    while (fd_cnt == 0 && cyc < bound) begin
      if (cyc == mid_fs_cyc) s_fs = 1;
      s_step();
      s_fs = 0;
    end
    chk("frame_done_seen", fd_cnt, 1);
    chk("saves_per_frame", saves, 8);
    chk("frame_done_cyc", fd_cyc, fd_exp);
    s_step();
    chk("done_single_pulse", s_fd, 0);
    chk("idle_busy", s_busy, 0);
  endtask

  int bcyc, bsaves, bmax, bgap_err, blast_save, bfd_cyc;
  logic [12:0] blast_mbn;
  logic [6:0]  blast_x;
  logic [5:0]  blast_y;

  initial begin
    // reset asserted asynchronously between clock edges
    #2 rst_n = 0;
    #1;
    chk("rst_outputs", {s_busy, s_fd, s_lr, s_ps, s_save, s_top, s_left, s_perr, s_x, s_y, s_mbn}, 0);
    chk("rst_outputs_big", {b_busy, b_fd, b_lr, b_ps, b_save, b_perr, b_mbn}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // 1+2: ack/done tied high, 6-cycle cadence, raster wrap and edge flags
    tied = 1; ack_delay = 0; done_delay = 1; stray_mb = -1; hang_mb = -1;
    gap_exp = 6; first_exp = 4; mid_fs_cyc = -1;
    run_frame(49, 200);

    // 3: ack after 5 extra cycles, done 7 cycles after pred_start
    tied = 0; s_ack = 0; s_done = 0;
    @(negedge clk);
    ack_delay = 5; done_delay = 7; gap_exp = 17; first_exp = 15;
    run_frame(137, 400);
    chk("perr_clean_handshake", s_perr, 0);

    // 4: stray pred_done in the pred_start cycle of mb 0, frame_start mid-frame
    ack_delay = 0; done_delay = 1; gap_exp = 6; first_exp = 4;
    stray_mb = 0; mid_fs_cyc = 10;
    run_frame(49, 200);
    chk("perr_sticky", s_perr, 1);
    stray_mb = -1; mid_fs_cyc = -1;

    // 5: reset while mb 5 waits for pred_done
    hang_mb = 5;
    start_frame();
    while (!(armed && s_mbn == 5 && pc >= 2) && cyc < 100) s_step();
    chk("hang_mbn", s_mbn, 5);
    chk("hang_busy", s_busy, 1);
    #2 rst_n = 0;
    #1;
    chk("midframe_rst_outputs", {s_busy, s_fd, s_lr, s_ps, s_save, s_top, s_left, s_perr, s_x, s_y, s_mbn}, 0);
    s_done = 0; s_ack = 0;
    repeat (2) @(negedge clk);
    chk("no_done_in_reset", s_fd, 0);
    rst_n = 1;
    hang_mb = -1;
    @(negedge clk);
    chk("idle_after_rst", s_busy, 0);
    run_frame(49, 200);

    // 6: full 1280x720, SAVE_LAT=0, ack/done tied high
    b_ack = 1; b_done = 1; b_fs = 1;
    bcyc = 0; bsaves = 0; bmax = 0; bgap_err = 0; blast_save = 0; bfd_cyc = 0;
    blast_mbn = '0; blast_x = '0; blast_y = '0;
    @(negedge clk);
    bcyc = 1;
    b_fs = 0;
    while (bfd_cyc == 0 && bcyc < 20000) begin
      @(negedge clk);
      bcyc++;
      if (b_mbn > bmax) bmax = b_mbn;
      if (b_save) begin
        if (bsaves > 0 && bcyc - blast_save != 5) bgap_err++;
        blast_save = bcyc;
        blast_mbn  = b_mbn;
        blast_x    = b_x;
        blast_y    = b_y;
        bsaves++;
      end
      if (b_fd) bfd_cyc = bcyc;
    end
    chk("big_saves", bsaves, 3600);
    chk("big_gap_errs", bgap_err, 0);
    chk("big_last_mbn", blast_mbn, 3599);
    chk("big_last_x", blast_x, 79);
    chk("big_last_y", blast_y, 44);
    chk("big_max_mbn", bmax, 3599);
    chk("big_done_cyc", bfd_cyc, 18001);
    @(negedge clk);
    chk("big_idle_mbn", b_mbn, 3599);
    chk("big_idle_busy", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
